// File: rtl/ifetch_if.sv
// Fetch-stage bundle: redirect/inhibit control, byte-wide memory read port and decode-side word handshake.
// master = fetch unit, slave = surrounding environment (memory + decode).
interface ifetch_if #(
   parameter int INSN_BYTES = 4,
   parameter int DEPTH      = 4
);
   logic                      pc_inhibit;
   logic                      redirect_valid;
   logic [63:0]               redirect_pc;
   logic                      mem_req;
   logic [63:0]               mem_addr;
   logic                      mem_ack;
   logic [7:0]                mem_data;
   logic                      insn_valid;
   logic [8*INSN_BYTES-1:0]   insn_data;
   logic [63:0]               insn_pc;
   logic                      insn_ready;
   logic [$clog2(DEPTH):0]    fifo_level;

   modport master (
      input  pc_inhibit, redirect_valid, redirect_pc, mem_ack, mem_data, insn_ready,
      output mem_req, mem_addr, insn_valid, insn_data, insn_pc, fifo_level
   );

   modport slave (
      output pc_inhibit, redirect_valid, redirect_pc, mem_ack, mem_data, insn_ready,
      input  mem_req, mem_addr, insn_valid, insn_data, insn_pc, fifo_level
   );
endinterface

// File: rtl/ifetch.sv
// Byte-serial instruction fetch: assembles little-endian words and queues them for decode.
// Define IFETCH_PERF_EN to add the perf_words / perf_stall counters.
module ifetch #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          INSN_BYTES = 4,
   parameter int          DEPTH      = 4
) (
   input  logic         clk,
   input  logic         reset,
   ifetch_if.master     bus
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]  perf_words,
   output logic [31:0]  perf_stall
`endif
);
   localparam int WORD_W = 8 * INSN_BYTES;
   localparam int CNT_W  = (INSN_BYTES > 1) ? $clog2(INSN_BYTES) : 1;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INSN_BYTES - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [63:0]         pc_q, pc_d;
   logic [63:0]         addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   lane_s;
   logic                push_s;
   logic                pop_s;
   logic                empty_s;
   logic [PTR_W-1:0]    wr_q, wr_d;
   logic [PTR_W-1:0]    rd_q, rd_d;
   logic [LVL_W-1:0]    lvl_q, lvl_d;
   logic [WORD_W-1:0]   data_mem_q [DEPTH];
   logic [63:0]         pc_mem_q [DEPTH];
   logic [WORD_W-1:0]   head_data_s;
   logic [63:0]         head_pc_s;
   logic [WORD_W-1:0]   last_data_q, last_data_d;
   logic [63:0]         last_pc_q, last_pc_d;

   assign empty_s     = (lvl_q == LVL_W'(0));
   assign head_data_s = data_mem_q[rd_q];
   assign head_pc_s   = pc_mem_q[rd_q];

   // Fetch FSM next state; a redirect always wins over ack/push.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      push_s  = 1'b0;
      for (int i = 0; i < INSN_BYTES; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            lane_s[i*8 +: 8] = bus.mem_data;
         end else begin
            lane_s[i*8 +: 8] = word_q[i*8 +: 8];
         end
      end
      case (state_q)
         ST_IDLE: begin
            // No word can be in flight while idle, so the pending push term is zero here.
            if (bus.redirect_valid) begin
               pc_d = bus.redirect_pc;
            end else if (!bus.pc_inhibit && (lvl_q < FULL_LVL)) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               cnt_d   = CNT_W'(0);
               state_d = bus.mem_ack ? ST_IDLE : ST_DRAIN;
            end else if (bus.mem_ack && (cnt_q == LAST_CNT)) begin
               push_s  = 1'b1;
               word_d  = lane_s;
               pc_d    = pc_q + 64'(INSN_BYTES);
               cnt_d   = CNT_W'(0);
               state_d = ST_IDLE;
            end else if (bus.mem_ack) begin
               word_d  = lane_s;
               cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (bus.redirect_valid) begin
               pc_d = bus.redirect_pc;
            end else begin
               pc_d = pc_q;
            end
            if (bus.mem_ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(0);
         end
      endcase
      // An abandoned request keeps its original address until the memory acknowledges it.
      addr_d = (state_d == ST_DRAIN) ? addr_q : (pc_d + 64'(cnt_d));
   end

   // Fetch FSM and word-assembly registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         cnt_q   <= CNT_W'(0);
         word_q  <= WORD_W'(0);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

   // FIFO pointer/level update; a flush cancels any same-cycle push or pop.
   always_comb begin
      pop_s       = bus.insn_ready && !empty_s && !bus.redirect_valid;
      wr_d        = wr_q;
      rd_d        = rd_q;
      lvl_d       = lvl_q;
      last_data_d = last_data_q;
      last_pc_d   = last_pc_q;
      if (bus.redirect_valid) begin
         wr_d  = PTR_W'(0);
         rd_d  = PTR_W'(0);
         lvl_d = LVL_W'(0);
         if (!empty_s) begin
            last_data_d = head_data_s;
            last_pc_d   = head_pc_s;
         end else begin
            last_data_d = last_data_q;
            last_pc_d   = last_pc_q;
         end
      end else begin
         wr_d  = push_s ? (wr_q + PTR_W'(1)) : wr_q;
         rd_d  = pop_s  ? (rd_q + PTR_W'(1)) : rd_q;
         lvl_d = lvl_q + LVL_W'(push_s) - LVL_W'(pop_s);
         if (pop_s) begin
            last_data_d = head_data_s;
            last_pc_d   = head_pc_s;
         end else begin
            last_data_d = last_data_q;
            last_pc_d   = last_pc_q;
         end
      end
   end

   // FIFO control registers and the value shown to decode once the FIFO drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q        <= PTR_W'(0);
         rd_q        <= PTR_W'(0);
         lvl_q       <= LVL_W'(0);
         last_data_q <= WORD_W'(0);
         last_pc_q   <= 64'h0;
      end else begin
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         lvl_q       <= lvl_d;
         last_data_q <= last_data_d;
         last_pc_q   <= last_pc_d;
      end
   end

   // FIFO storage; push_s is already suppressed on a redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= WORD_W'(0);
            pc_mem_q[i]   <= 64'h0;
         end
      end else if (push_s) begin
         data_mem_q[wr_q] <= lane_s;
         pc_mem_q[wr_q]   <= pc_q;
      end
   end

   assign bus.mem_req    = (state_q != ST_IDLE);
   assign bus.mem_addr   = addr_q;
   assign bus.insn_valid = !empty_s;
   assign bus.insn_data  = empty_s ? last_data_q : head_data_s;
   assign bus.insn_pc    = empty_s ? last_pc_q : head_pc_s;
   assign bus.fifo_level = lvl_q;

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_words_q;
   logic [31:0] perf_stall_q;
   logic        stall_s;

   assign stall_s = (state_q == ST_IDLE) && !bus.pc_inhibit && !bus.redirect_valid
                    && (lvl_q == FULL_LVL);

   // Free-running event counters, untouched by redirects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_words_q <= 32'h0;
         perf_stall_q <= 32'h0;
      end else begin
         perf_words_q <= perf_words_q + 32'(push_s);
         perf_stall_q <= perf_stall_q + 32'(stall_s);
      end
   end

   assign perf_words = perf_words_q;
   assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by randomized traffic against a PC-stream model.
module tb_ifetch;
   localparam logic [63:0] RST_PC = 64'h1000;
   localparam int NB = 4;
   localparam int DP = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   ifetch_if #(.INSN_BYTES(NB), .DEPTH(DP)) bus();
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_words;
   logic [31:0] perf_stall;
`endif

   ifetch #(.RESET_PC(RST_PC), .INSN_BYTES(NB), .DEPTH(DP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef IFETCH_PERF_EN
      ,
      .perf_words (perf_words),
      .perf_stall (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int          total    = 0;
   int          bad      = 0;
   int          pops     = 0;
   int          ack_pct  = 100;
   int          hold_cnt = 0;
   logic [63:0] exp_pc   = 64'h0;

   // Memory content: a byte derived from its own address.
   function automatic logic [7:0] mbyte(input logic [63:0] a);
      return a[7:0] ^ a[23:16];
   endfunction

   // Little-endian word as it should appear at byte address a (64-bit wrap).
   function automatic logic [31:0] word_at(input logic [63:0] a);
      logic [31:0] w;
      for (int i = 0; i < NB; i++) w[i*8 +: 8] = mbyte(a + 64'(i));
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: drive memory response, score any pop, then check the request hold rule.
   task automatic step();
      logic        req_b;
      logic        ack_b;
      logic [63:0] addr_b;
      req_b  = bus.mem_req;
      addr_b = bus.mem_addr;
      if (req_b && hold_cnt > 0) begin
         ack_b = 1'b0;
         hold_cnt--;
      end else if (req_b) begin
         ack_b = ($urandom_range(99) < ack_pct);
      end else begin
         ack_b = 1'b0;
      end
      bus.mem_ack  = ack_b;
      bus.mem_data = ack_b ? mbyte(addr_b) : 8'($urandom);
      if (bus.insn_valid && bus.insn_ready && !bus.redirect_valid) begin
         chk("pop_pc", bus.insn_pc, exp_pc);
         chk("pop_data", 64'(bus.insn_data), 64'(word_at(exp_pc)));
         exp_pc = exp_pc + 64'(NB);
         pops++;
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
      @(posedge clk);
      #1;
      if (req_b && !ack_b) begin
         chk("req_held", 64'(bus.mem_req), 64'd1);
         chk("addr_held", bus.mem_addr, addr_b);
      end
      if (bus.fifo_level > 3'(DP)) chk("level_max", 64'(bus.fifo_level), 64'(DP));
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!bus.insn_valid && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(bus.insn_valid), 64'd1);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (!bus.mem_req && n < budget) begin
         step();
         n++;
      end
      chk(tag, 64'(bus.mem_req), 64'd1);
   endtask

   task automatic do_reset();
      reset              = 1'b1;
      bus.pc_inhibit     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'h0;
      bus.mem_ack        = 1'b0;
      bus.mem_data       = 8'h00;
      bus.insn_ready     = 1'b0;
      hold_cnt           = 0;
      ack_pct            = 100;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      exp_pc = RST_PC;
      pops   = 0;
   endtask

   initial begin
      int seen;
      // Reset values
      do_reset();
      chk("rst_req", 64'(bus.mem_req), 64'd0);
      chk("rst_addr", bus.mem_addr, RST_PC);
      chk("rst_valid", 64'(bus.insn_valid), 64'd0);
      chk("rst_data", 64'(bus.insn_data), 64'd0);
      chk("rst_pc", bus.insn_pc, 64'd0);
      chk("rst_level", 64'(bus.fifo_level), 64'd0);

      // First two words with ack every cycle
      bus.insn_ready = 1'b1;
      wait_valid("t1_v1", 10);
      chk("t1_data1", 64'(bus.insn_data), 64'h0302_0100);
      chk("t1_pc1", bus.insn_pc, 64'h1000);
      step();
      wait_valid("t1_v2", 10);
      chk("t1_data2", 64'(bus.insn_data), 64'h0706_0504);
      chk("t1_pc2", bus.insn_pc, 64'h1004);

      // Back-pressure fills the FIFO, one pop lets the fifth fetch start
      do_reset();
      repeat (30) step();
      chk("t2_level", 64'(bus.fifo_level), 64'd4);
      chk("t2_noreq", 64'(bus.mem_req), 64'd0);
      chk("t2_head", bus.insn_pc, 64'h1000);
      bus.insn_ready = 1'b1;
      step();
      bus.insn_ready = 1'b0;
      chk("t2_level3", 64'(bus.fifo_level), 64'd3);
      wait_req("t2_req", 4);
      chk("t2_addr", bus.mem_addr, 64'h1010);

      // pc_inhibit raised after two bytes: word completes, then no request
      do_reset();
      bus.insn_ready = 1'b1;
      wait_req("t3_req", 5);
      step();
      step();
      bus.pc_inhibit = 1'b1;
      step();
      step();
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.mem_req) seen = 1;
      end
      chk("t3_noreq", 64'(seen), 64'd0);
      chk("t3_words", 64'(pops), 64'd1);
      bus.pc_inhibit = 1'b0;
      wait_req("t3_resume", 5);
      chk("t3_addr", bus.mem_addr, 64'h1004);

      // Redirect while a request waits three cycles for its ack
      do_reset();
      bus.insn_ready = 1'b1;
      wait_req("t4_req", 5);
      hold_cnt           = 3;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h2000;
      step();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_req", 64'(bus.mem_req), 64'd1);
         chk("t4_hold_addr", bus.mem_addr, 64'h1000);
         step();
      end
      chk("t4_level", 64'(bus.fifo_level), 64'd0);
      chk("t4_valid", 64'(bus.insn_valid), 64'd0);
      wait_req("t4_req2", 4);
      chk("t4_addr", bus.mem_addr, 64'h2000);
      wait_valid("t4_v", 10);
      chk("t4_pc", bus.insn_pc, 64'h2000);

      // PC wrap at the top of the address space
      do_reset();
      bus.insn_ready     = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      wait_valid("t5_v1", 10);
      chk("t5_pc1", bus.insn_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t5_data1", 64'(bus.insn_data), 64'h0001_0203);
      step();
      wait_valid("t5_v2", 10);
      chk("t5_pc2", bus.insn_pc, 64'h0);
      chk("t5_data2", 64'(bus.insn_data), 64'h0302_0100);

      // Asynchronous reset during an outstanding request
      do_reset();
      wait_valid("t6_v", 10);
      step();
      chk("t6_pre_req", 64'(bus.mem_req), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_req", 64'(bus.mem_req), 64'd0);
      chk("t6_level", 64'(bus.fifo_level), 64'd0);
      @(posedge clk);
      #1;
      reset          = 1'b0;
      exp_pc         = RST_PC;
      bus.insn_ready = 1'b1;
      wait_valid("t6_v2", 10);
      chk("t6_pc", bus.insn_pc, RST_PC);

      // Randomized traffic: ack gaps, back-pressure, inhibit and redirects
      do_reset();
      for (int blk = 0; blk < 6; blk++) begin
         ack_pct = 40 + 12 * blk;
         for (int c = 0; c < 400; c++) begin
            bus.insn_ready     = ($urandom_range(1) == 1);
            bus.pc_inhibit     = ($urandom_range(9) == 0);
            bus.redirect_valid = ($urandom_range(29) == 0);
            if ($urandom_range(3) == 0) begin
               bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            end else begin
               bus.redirect_pc = {32'($urandom), 32'($urandom)};
            end
            step();
         end
      end
      bus.redirect_valid = 1'b0;
      chk("rand_pops", 64'(pops > 50), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage directly upstream of the processing domain's control unit.
- Issues byte-wide reads to the cache/memory port starting at the program counter.
- Assembles INSN_BYTES consecutive bytes into little-endian instruction words and buffers them in a small FIFO.
- Presents words to decode with a valid/ready handshake; honours pc_inhibit and branch redirects.

Parameters:
- RESET_PC, 64'h0, program counter value loaded on reset.
- INSN_BYTES, 4, bytes per instruction word (1..8); word width = 8*INSN_BYTES.
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- pc_inhibit  in  1  when high, no new word fetch is started
- redirect_valid  in  1  one-cycle pulse: load redirect_pc, flush
- redirect_pc  in  64  new fetch address
- mem_req  out  1  read request
- mem_addr  out  64  byte address of request
- mem_ack  in  1  memory accepted request; mem_data valid this cycle
- mem_data  in  8  read byte
- insn_valid  out  1  FIFO head valid
- insn_data  out  8*INSN_BYTES  FIFO head word
- insn_pc  out  64  address of first byte of head word
- insn_ready  in  1  decode consumes head when insn_valid && insn_ready
- fifo_level  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, byte_cnt=0, FSM=IDLE, FIFO empty, discard=0. Outputs: mem_req=0, mem_addr=RESET_PC, insn_valid=0, insn_data=0, insn_pc=0, fifo_level=0.
- FSM IDLE -> FETCH when !pc_inhibit && !redirect_valid && (fifo_level + pending_push) < DEPTH. pending_push is a word in flight that will push this cycle.
- FETCH: mem_req=1, mem_addr=pc+byte_cnt. Address is held stable until mem_ack is sampled high on a rising edge.
  - On ack: byte lands in lane byte_cnt (little-endian), byte_cnt++.
  - mem_req stays high for the next byte in the following cycle.
- When the last byte (byte_cnt==INSN_BYTES-1) is acked:
  - Word plus pc is pushed into the FIFO the same edge.
  - pc += INSN_BYTES, wrapping modulo 2^64.
  - byte_cnt=0; FSM -> IDLE.
  - Each word therefore costs at least INSN_BYTES+1 cycles.
- pc_inhibit only gates IDLE->FETCH; a word already in FETCH completes.
- FIFO: head drives insn_* combinationally from storage.
  - Push and pop in the same cycle are both legal, including when the FIFO is full; fifo_level is unchanged.
  - Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - insn_data and insn_pc hold their last value when empty.
- Redirect (highest priority) on the edge where redirect_valid=1:
  - FIFO cleared (fifo_level=0, insn_valid=0 next cycle).
  - byte_cnt=0; pc=redirect_pc; any same-cycle push or pop is cancelled.
  - If mem_req=1 and mem_ack=0 that cycle: mem_req stays high at the old address until ack, that byte is discarded (discard=1), then FSM -> IDLE.
  - If mem_ack=1 that same cycle, the byte is discarded and FSM -> IDLE.
  - mem_req never drops before ack.
- A redirect arriving while discard=1 just updates pc.
- Reset mid-request drops mem_req immediately; the memory side must tolerate an abandoned request.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_words (32 bits, words pushed) and perf_stall (32 bits, cycles in IDLE with pc_inhibit=0, no redirect and FIFO full).
  - Both reset to 0 and wrap at 2^32.
  - Both are unaffected by redirect.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0x1000, memory acks every cycle with byte = addr[7:0], insn_ready=1 -> first insn_valid with insn_data=0x03020100, insn_pc=0x1000; next word 0x07060504 at pc 0x1004.
- insn_ready=0, DEPTH=4 -> exactly 4 words fetched, fifo_level=4, mem_req stays 0. Raise insn_ready for 1 cycle -> one pop, fetch of the 5th word at 0x1010 resumes.
- pc_inhibit raised mid-word (after 2 bytes acked) -> word completes and is pushed, no further mem_req until pc_inhibit=0.
- redirect_pc=0x2000 while a request is outstanding with ack delayed 3 cycles -> mem_addr holds until ack, byte discarded, FIFO empty, next mem_addr=0x2000, next insn_pc=0x2000.
- redirect_pc=0xFFFFFFFFFFFFFFFC -> word at that pc, following word insn_pc=0x0 (wrap).
- Assert reset asynchronously while mem_req=1 -> mem_req=0 and fifo_level=0 before the next clock edge; fetch restarts at RESET_PC.
